bist_harness: RTL
=================

Name: bist_harness

Overview:
- Parametrised self-test harness for clocked combinational benchmark wrappers (c17 and larger ISCAS circuits).
- An LFSR pattern generator drives NUM_IN DUT inputs; the DUT outputs (NUM_OUT bits) are compacted into a MISR signature after a configurable DUT latency.
- A control FSM sequences the run and reports done/pass against an expected signature.
- Sits beside the DUT in simulation and synthesis, replacing hand-written per-vector testbench stimulus.

Parameters:
- NUM_IN, 5: DUT input width, which is also the LFSR width (≥2).
- NUM_OUT, 2: DUT output width.
- SIG_W, 16: MISR signature width (≥NUM_OUT).
- LFSR_POLY, 5'b10100: LFSR tap mask, width NUM_IN.
- MISR_POLY, 16'hB400: MISR tap mask, width SIG_W.
- DUT_LAT, 0: DUT response latency in cycles (0..8).
- CNT_W, 16: pattern counter width.

Ports:
- clock, in, 1: single clock, rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- start, in, 1: begin run; sampled only in IDLE or DONE.
- abort, in, 1: terminate run and return to IDLE.
- seed, in, NUM_IN: LFSR seed, sampled on accepted start.
- pat_count, in, CNT_W: number of patterns, sampled on accepted start.
- expected_sig, in, SIG_W: golden signature, compared in DONE.
- dut_in, out, NUM_IN: stimulus to the DUT.
- dut_out, in, NUM_OUT: DUT response.
- busy, out, 1: high in RUN and DRAIN.
- done, out, 1: high in DONE.
- pass, out, 1: signature == expected_sig; valid while done.
- signature, out, SIG_W: MISR contents.
- patterns_applied, out, CNT_W: count of patterns driven.

Behaviour:
- Reset (reset_n low at a clock edge): state IDLE; dut_in, signature and patterns_applied are 0; busy, done and pass are 0; the valid pipeline is cleared. Reset takes effect from any state, including mid-run.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - dut_in is held at 0.
  - On start=1 with pat_count=0: go to DONE; signature=0.
  - On start=1 with pat_count>0: go to RUN. LFSR=seed, but a seed of all zeros is replaced by 1 to avoid lockup. signature and patterns_applied are cleared.
- RUN:
  - dut_in = LFSR each cycle.
  - LFSR next = {lfsr[NUM_IN-2:0], ^(lfsr & LFSR_POLY)}.
  - patterns_applied increments each cycle.
  - After pat_count cycles, go to DRAIN if DUT_LAT>0, otherwise to DONE.
- Capture:
  - A DUT_LAT-deep valid shift register tracks applied patterns.
  - When the tracked pattern emerges (same cycle if DUT_LAT=0), MISR next = {misr[SIG_W-2:0], ^(misr & MISR_POLY)} ^ zero-extend(dut_out).
  - Exactly pat_count responses are compacted; no sample is taken outside valid cycles.
- DRAIN:
  - dut_in holds the last pattern.
  - Stay DUT_LAT cycles, then go to DONE.
- DONE:
  - done=1; pass = (signature == expected_sig), registered on entry.
  - Outputs hold.
  - start restarts exactly as from IDLE; all other inputs are ignored.
- Timing: done is first seen high pat_count+DUT_LAT cycles after the start-accept edge.
- start in RUN or DRAIN is ignored.
- abort in RUN or DRAIN:
  - Next state IDLE; dut_in=0; done=0; valid pipeline cleared.
  - signature and patterns_applied are retained for debug.
  - abort and start together: abort wins.
- patterns_applied saturates at 2^CNT_W-1; it never wraps.

Decomposition:
- Package bist_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - default polynomial constants (5-bit and 16-bit);
  - MAX_DUT_LAT=8.
- One sub-module, misr_compactor: parameters SIG_W, IN_W, POLY; ports clock, reset_n, clear, en, data_in, sig.
- The LFSR stays inline.

Test Plan:
- LFSR sequence: seed=5'b00001, pat_count=6, loopback dut_out=dut_in[1:0] -> dut_in sequence 00001, 00010, 00100, 01001, 10010, 00101; patterns_applied=6; signature matches the bench MISR model.
- Zero seed: seed=0, pat_count=3 -> first dut_in=00001, i.e. identical to the seed=1 run.
- c17 with pass and fail:
  - DUT_LAT=0, pat_count=31, expected_sig = model value -> done at cycle 31 after start, pass=1;
  - rerun with expected_sig XOR 1 -> pass=0.
- Latency: c17 registered twice, DUT_LAT=2, pat_count=10 -> busy for 12 cycles, done at cycle 12; signature equals the DUT_LAT=0 run on the unregistered c17.
- Edge cases:
  - pat_count=0 -> DONE on the next edge, signature=0, pass=(expected_sig==0);
  - start pulsed mid-RUN -> no effect on count or signature.
- Abort and reset:
  - abort at RUN cycle 4 -> IDLE, dut_in=0, patterns_applied=4, done=0;
  - reset_n=0 at RUN cycle 4 -> all outputs 0 on the next edge, and a fresh start then runs normally.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared state encoding and default polynomials for the BIST harness.
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [4:0]  LFSR_POLY_5  = 5'b10100;
   localparam logic [15:0] MISR_POLY_16 = 16'hB400;
   localparam int unsigned MAX_DUT_LAT  = 8;

endpackage

// File: rtl/misr_compactor.sv
// Multiple-input signature register: shift with polynomial feedback, then fold in the response word.
module misr_compactor
   import bist_pkg::*;
#(
   parameter int unsigned      SIG_W = 16,
   parameter int unsigned      IN_W  = 2,
   parameter logic [SIG_W-1:0] POLY  = MISR_POLY_16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             en,
   input  logic [IN_W-1:0]  data_in,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = {sig_q[SIG_W-2:0], ^(sig_q & POLY)} ^ SIG_W'(data_in);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/bist_harness.sv
// Self-test harness: LFSR drives the DUT, a latency-aligned MISR compacts its responses,
// and a control FSM reports done/pass against a golden signature.
module bist_harness
   import bist_pkg::*;
#(
   parameter int unsigned       NUM_IN    = 5,
   parameter int unsigned       NUM_OUT   = 2,
   parameter int unsigned       SIG_W     = 16,
   parameter logic [NUM_IN-1:0] LFSR_POLY = LFSR_POLY_5,
   parameter logic [SIG_W-1:0]  MISR_POLY = MISR_POLY_16,
   parameter int unsigned       DUT_LAT   = 0,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [NUM_IN-1:0]  seed,
   input  logic [CNT_W-1:0]   pat_count,
   input  logic [SIG_W-1:0]   expected_sig,
   output logic [NUM_IN-1:0]  dut_in,
   input  logic [NUM_OUT-1:0] dut_out,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [SIG_W-1:0]   signature,
   output logic [CNT_W-1:0]   patterns_applied
);

   localparam int unsigned DRN_W = $clog2(MAX_DUT_LAT + 1);

   state_e            state_q, state_d;
   logic [NUM_IN-1:0] lfsr_q, lfsr_d;
   logic [CNT_W-1:0]  applied_q, applied_d;
   logic [CNT_W-1:0]  pat_q, pat_d;
   logic [DRN_W-1:0]  drain_q, drain_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;

   logic              active_c;
   logic              abort_c;
   logic              capture_c;
   logic              misr_en_c;
   logic              misr_clear_c;
   logic [NUM_IN-1:0] lfsr_step_c;
   logic [SIG_W-1:0]  sig_step_c;
   logic [SIG_W-1:0]  sig_next_c;

   assign active_c    = (state_q == RUN) || (state_q == DRAIN);
   assign abort_c     = abort && active_c;
   assign lfsr_step_c = {lfsr_q[NUM_IN-2:0], ^(lfsr_q & LFSR_POLY)};
   assign sig_step_c  = {signature[SIG_W-2:0], ^(signature & MISR_POLY)} ^ SIG_W'(dut_out);
   assign misr_en_c   = capture_c && !abort_c;
   // Signature as it will stand after this edge; lets pass be registered on DONE entry.
   assign sig_next_c  = misr_en_c ? sig_step_c : signature;

   // Valid tracking: a pattern driven in RUN reaches the capture point DUT_LAT cycles later.
   generate
      if (DUT_LAT == 0) begin : g_nolat
         assign capture_c = (state_q == RUN);
      end else begin : g_lat
         logic [DUT_LAT-1:0] vpipe_q;
         logic [DUT_LAT-1:0] vpipe_d;

         always_comb begin
            vpipe_d = (vpipe_q << 1) | DUT_LAT'(state_q == RUN);
            if (abort_c) begin
               vpipe_d = '0;
            end
         end

         always_ff @(posedge clock) begin
            if (!reset_n) begin
               vpipe_q <= '0;
            end else begin
               vpipe_q <= vpipe_d;
            end
         end

         assign capture_c = vpipe_q[DUT_LAT-1];
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      applied_d    = applied_q;
      pat_d        = pat_q;
      drain_d      = drain_q;
      pass_d       = pass_q;
      misr_clear_c = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               misr_clear_c = 1'b1;
               pat_d        = pat_count;
               applied_d    = '0;
               pass_d       = 1'b0;
               lfsr_d       = '0;
               if (pat_count == '0) begin
                  state_d = DONE;
                  pass_d  = (expected_sig == '0);
               end else begin
                  state_d   = RUN;
                  lfsr_d    = (seed == '0) ? NUM_IN'(1) : seed;
                  applied_d = CNT_W'(1);
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               lfsr_d  = '0;
            end else if (applied_q == pat_q) begin
               if (DUT_LAT == 0) begin
                  state_d = DONE;
                  pass_d  = (sig_next_c == expected_sig);
               end else begin
                  state_d = DRAIN;
                  drain_d = DRN_W'(1);
               end
            end else begin
               lfsr_d = lfsr_step_c;
               if (applied_q != '1) begin
                  applied_d = applied_q + CNT_W'(1);
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               state_d = IDLE;
               lfsr_d  = '0;
               drain_d = '0;
            end else if (drain_q == DRN_W'(DUT_LAT)) begin
               state_d = DONE;
               pass_d  = (sig_next_c == expected_sig);
            end else begin
               drain_d = drain_q + DRN_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         lfsr_q    <= '0;
         applied_q <= '0;
         pat_q     <= '0;
         drain_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         applied_q <= applied_d;
         pat_q     <= pat_d;
         drain_q   <= drain_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
      end
   end

   misr_compactor #(
      .SIG_W (SIG_W),
      .IN_W  (NUM_OUT),
      .POLY  (MISR_POLY)
   ) u_misr (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (misr_clear_c),
      .en      (misr_en_c),
      .data_in (dut_out),
      .sig     (signature)
   );

   assign dut_in           = lfsr_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign patterns_applied = applied_q;

endmodule
